// File: rtl/uart_fmt_pkg.sv
// Shared constants and helpers for the numeric-to-ASCII record formatter.
package uart_fmt_pkg;

   // Ten BCD digits hold any 32-bit unsigned value (max 4294967295).
   localparam int DIGITS_DEF = 10;
   localparam int VALUE_W    = 32;

   // One-hot FSM encoding.
   localparam logic [4:0] ST_IDLE = 5'b00001;
   localparam logic [4:0] ST_CONV = 5'b00010;
   localparam logic [4:0] ST_PACK = 5'b00100;
   localparam logic [4:0] ST_REQ  = 5'b01000;
   localparam logic [4:0] ST_WAIT = 5'b10000;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_EQ   = 8'h3D;

   // Double-dabble correction: a nibble of 5 or more becomes >= 8 after
   // adding 3, so the following shift carries it into the next digit.
   function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
   import uart_fmt_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  start,
   input  logic [VALUE_W-1:0]    bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;

   logic [VALUE_W-1:0] bin_sr;
   logic [5:0]         iter_cnt;
   logic [BCD_W-1:0]   bcd_adj;

   // Apply the add-3 correction to every digit before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
      end
   end

   // Load on start, then shift {bcd, bin} once per cycle while the
   // iteration down-counter is nonzero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bin_sr   <= '0;
         bcd      <= '0;
         iter_cnt <= '0;
      end else if (start) begin
         bin_sr   <= bin;
         bcd      <= '0;
         iter_cnt <= 6'(VALUE_W);
      end else if (iter_cnt != 6'd0) begin
         bcd      <= {bcd_adj[BCD_W-2:0], bin_sr[VALUE_W-1]};
         bin_sr   <= {bin_sr[VALUE_W-2:0], 1'b0};
         iter_cnt <= iter_cnt - 6'd1;
      end
   end

   // Done is high during the cycle whose closing edge performs the final
   // iteration, so the caller can change state on that same edge.
   assign done = (iter_cnt == 6'd1);

endmodule

// File: rtl/uart_num_formatter.sv
// Formats a 32-bit unsigned value as "<tag>=<decimal>" on the framer's
// string bus and hands it over with a single-cycle request.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for data_vld; on accept clears string, writes tag,'='
// CONV  | binary-to-BCD engine running (32 cycles)
// PACK  | one BCD digit per cycle, MSD first, leading zeros suppressed
// REQ   | record ready; pulse tx_req once framer is not busy
// WAIT  | record owned by framer until tx_done
module uart_num_formatter
   import uart_fmt_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int STR_W  = 1096
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               data_vld,
   input  logic [VALUE_W-1:0] value,
   input  logic [7:0]         tag,
   output logic               busy,
   output logic               drop,
   output logic [STR_W-1:0]   tx_string,
   output logic [7:0]         tx_length,
   output logic               tx_req,
   input  logic               tx_busy,
   input  logic               tx_done
);

   localparam int BCD_W   = 4 * DIGITS;
   localparam int N_BYTES = 2 + DIGITS;

   logic [4:0]       state;
   logic             conv_start;
   logic             conv_done;
   logic [BCD_W-1:0] bcd;
   logic [7:0]       ptr;
   logic [7:0]       dig_idx;
   logic             seen;
   logic [3:0]       digit;
   logic             emit;

   assign conv_start = (state == ST_IDLE) && data_vld;
   assign busy       = (state != ST_IDLE);

   bin2bcd_seq #(
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (conv_start),
      .bin       (value),
      .done      (conv_done),
      .bcd       (bcd)
   );

   // Select the digit currently being packed.
   always_comb begin
      digit = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_idx == 8'(i)) begin
            digit = bcd[4*i +: 4];
         end
      end
   end

   // The least significant digit is always emitted so zero prints as "0".
   assign emit = (digit != 4'h0) || seen || (dig_idx == 8'd0);

   // Main sequencer and record assembly.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         dig_idx   <= '0;
         seen      <= 1'b0;
         tx_string <= '0;
         tx_length <= '0;
         tx_req    <= 1'b0;
      end else begin
         tx_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (data_vld) begin
                  tx_string       <= '0;
                  tx_string[7:0]  <= tag;
                  tx_string[15:8] <= ASCII_EQ;
                  ptr             <= 8'd2;
                  state           <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (conv_done) begin
                  dig_idx <= 8'(DIGITS - 1);
                  seen    <= 1'b0;
                  state   <= ST_PACK;
               end
            end
            ST_PACK: begin
               if (emit) begin
                  for (int b = 2; b < N_BYTES; b++) begin
                     if (ptr == 8'(b)) begin
                        tx_string[8*b +: 8] <= ASCII_ZERO + {4'h0, digit};
                     end
                  end
                  ptr  <= ptr + 8'd1;
                  seen <= 1'b1;
               end
               if (dig_idx == 8'd0) begin
                  // Last digit is always emitted, so the final length is ptr+1.
                  tx_length <= ptr + 8'd1;
                  state     <= ST_REQ;
               end else begin
                  dig_idx <= dig_idx - 8'd1;
               end
            end
            ST_REQ: begin
               if (!tx_busy) begin
                  tx_req <= 1'b1;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (tx_done) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A strobe arriving while a record is in flight is discarded and flagged
   // one cycle later.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         drop <= 1'b0;
      end else begin
         drop <= data_vld && (state != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_num_formatter.sv
module tb_uart_num_formatter;

   localparam int DIGITS = 10;
   localparam int STR_W  = 1096;
   localparam int NB     = STR_W / 8;

   logic             sys_clk   = 1'b0;
   logic             sys_rst_n = 1'b1;
   logic             data_vld  = 1'b0;
   logic [31:0]      value     = '0;
   logic [7:0]       tag       = '0;
   logic             tx_busy   = 1'b0;
   logic             tx_done   = 1'b0;
   logic             busy;
   logic             drop;
   logic [STR_W-1:0] tx_string;
   logic [7:0]       tx_length;
   logic             tx_req;

   int n_checks = 0;
   int n_errors = 0;

   uart_num_formatter #(
      .DIGITS (DIGITS),
      .STR_W  (STR_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .data_vld  (data_vld),
      .value     (value),
      .tag       (tag),
      .busy      (busy),
      .drop      (drop),
      .tx_string (tx_string),
      .tx_length (tx_length),
      .tx_req    (tx_req),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 sys_clk = ~sys_clk;

   // Expected record built with plain decimal arithmetic.
   function automatic logic [STR_W-1:0] record_str(input logic [31:0] v, input logic [7:0] t);
      logic [STR_W-1:0] s;
      logic [7:0]       d[$];
      logic [31:0]      x;
      s       = '0;
      s[7:0]  = t;
      s[15:8] = 8'h3D;
      x       = v;
      do begin
         d.push_front(8'h30 + 8'(x % 32'd10));
         x = x / 32'd10;
      end while (x != 0);
      for (int i = 0; i < d.size(); i++) s[8*(i+2) +: 8] = d[i];
      return s;
   endfunction

   function automatic logic [7:0] record_len(input logic [31:0] v);
      logic [7:0]  n;
      logic [31:0] x;
      n = 8'd2;
      x = v;
      do begin
         n = n + 8'd1;
         x = x / 32'd10;
      end while (x != 0);
      return n;
   endfunction

   // Phase model: 0 idle, 1 converting (42 edges), 2 ready to request, 3 with framer.
   logic [1:0]       m_phase;
   int               m_cnt;
   logic             m_drop, m_req;
   logic [STR_W-1:0] m_str, p_str;
   logic [7:0]       m_len, p_len;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_phase <= 2'd0;
         m_cnt   <= 0;
         m_drop  <= 1'b0;
         m_req   <= 1'b0;
         m_str   <= '0;
         p_str   <= '0;
         m_len   <= '0;
         p_len   <= '0;
      end else begin
         m_drop <= data_vld && (m_phase != 2'd0);
         m_req  <= (m_phase == 2'd2) && !tx_busy;
         case (m_phase)
            2'd0: if (data_vld) begin
               m_phase <= 2'd1;
               m_cnt   <= 42;
               p_str   <= record_str(value, tag);
               p_len   <= record_len(value);
            end
            2'd1: begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) begin
                  m_phase <= 2'd2;
                  m_str   <= p_str;
                  m_len   <= p_len;
               end
            end
            2'd2: if (!tx_busy) m_phase <= 2'd3;
            default: if (tx_done) m_phase <= 2'd0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle_compare();
      chk("busy", 64'(busy), 64'(m_phase != 2'd0));
      chk("drop", 64'(drop), 64'(m_drop));
      chk("tx_req", 64'(tx_req), 64'(m_req));
      if (m_phase != 2'd1) begin
         chk("tx_length", 64'(tx_length), 64'(m_len));
         n_checks++;
         if (tx_string !== m_str) begin
            n_errors++;
            $display("FAIL tx_string: got low %h expected low %h (t=%0t)",
                     tx_string[127:0], m_str[127:0], $time);
         end
      end
   endtask

   // Advance one cycle: compare at the falling edge, return #1 after the rising edge.
   task automatic cyc();
      @(negedge sys_clk);
      if (sys_rst_n) cycle_compare();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input logic [7:0] t);
      data_vld = 1'b1;
      value    = v;
      tag      = t;
      cyc();
      data_vld = 1'b0;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (n < max) begin
         cyc();
         n++;
         if (tx_req === 1'b1) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: no tx_req within %0d cycles, expected one", max);
   endtask

   task automatic finish_tx();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
   endtask

   task automatic check_str(input string name, input string s);
      int bad;
      chk({name, " len"}, 64'(tx_length), 64'(s.len()));
      for (int i = 0; i < s.len(); i++)
         chk($sformatf("%s byte%0d", name, i), 64'(tx_string[8*i +: 8]), 64'(s[i]));
      bad = 0;
      for (int i = s.len(); i < NB; i++)
         if (tx_string[8*i +: 8] !== 8'h00) bad++;
      chk({name, " upper bytes zero"}, 64'(bad), 64'd0);
   endtask

   initial begin
      int n;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst drop", 64'(drop), 64'd0);
      chk("rst tx_req", 64'(tx_req), 64'd0);
      chk("rst tx_length", 64'(tx_length), 64'd0);
      chk("rst tx_string zero", 64'(tx_string == '0), 64'd1);
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      repeat (2) cyc();

      // Zero: single digit, 43-cycle latency.
      send(32'd0, 8'h46);
      wait_req(80, n);
      chk("latency zero", 64'(n), 64'd43);
      chk("zero byte2", 64'(tx_string[23:16]), 64'h30);
      check_str("zero", "F=0");
      finish_tx();
      repeat (2) cyc();

      send(32'd12345, 8'h46);
      wait_req(80, n);
      check_str("12345", "F=12345");
      finish_tx();

      // Back-to-back after tx_done, full-width maximum value.
      send(32'hFFFF_FFFF, 8'h54);
      wait_req(80, n);
      chk("latency max", 64'(n), 64'd43);
      check_str("max", "T=4294967295");
      finish_tx();
      repeat (2) cyc();

      // Framer busy holds the request off for 100 cycles after REQ is entered.
      tx_busy = 1'b1;
      send(32'd1000000, 8'h46);
      repeat (42) cyc();
      repeat (100) cyc();
      tx_busy = 1'b0;
      wait_req(5, n);
      chk("busy release latency", 64'(n), 64'd1);
      check_str("1000000", "F=1000000");
      finish_tx();
      repeat (2) cyc();

      // Strobe during CONV is dropped.
      send(32'd9, 8'h46);
      repeat (5) cyc();
      data_vld = 1'b1;
      value    = 32'd7;
      cyc();
      data_vld = 1'b0;
      chk("drop pulse", 64'(drop), 64'd1);
      cyc();
      chk("drop single", 64'(drop), 64'd0);
      wait_req(80, n);
      check_str("first record", "F=9");
      finish_tx();
      send(32'd7, 8'h46);
      wait_req(80, n);
      check_str("retry record", "F=7");
      finish_tx();
      repeat (2) cyc();

      // Reset during PACK aborts the record.
      send(32'd42, 8'h46);
      repeat (36) cyc();
      #2 sys_rst_n = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort drop", 64'(drop), 64'd0);
      chk("abort tx_req", 64'(tx_req), 64'd0);
      chk("abort tx_length", 64'(tx_length), 64'd0);
      chk("abort tx_string zero", 64'(tx_string == '0), 64'd1);
      repeat (3) cyc();
      sys_rst_n = 1'b1;
      n = 0;
      repeat (60) begin
         cyc();
         if (tx_req === 1'b1) n++;
      end
      chk("no req after abort", 64'(n), 64'd0);
      send(32'd42, 8'h46);
      wait_req(80, n);
      check_str("after reset", "F=42");
      finish_tx();
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
